// File: rtl/i2c_pkg.sv
// Shared I2C slave definitions: receive FSM states, byte framing constants
// and the slave address that the decode stage matches against.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    ACK_WAIT,
    ACK_BIT,
    ACK_END
  } rx_state_t;

  localparam int BYTE_BITS   = 8;
  localparam int ACK_BIT_IDX = 9;

  localparam logic [6:0] SLAVE_ADDR = 7'h78;

endpackage

// File: rtl/i2c_rx_timer_sync_high.sv
// Two-flop synchronizer for an asynchronous pad input; resets to 1 so an
// idle (pulled-up) bus never produces a spurious edge out of reset.
module sync_high (
  input  logic clk,
  input  logic n_rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q;
  logic meta_d;
  logic sync_q;
  logic sync_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/i2c_rx_timer.sv
// I2C slave receive bit timer: synchronizes scl/sda, shifts data MSB first on
// scl rise and frames each byte plus its ACK slot, under START/STOP control.
module i2c_rx_timer
  import i2c_pkg::*;
#(
  parameter int NUM_BITS = BYTE_BITS
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                scl,
  input  logic                sda_in,
  input  logic                start_found,
  input  logic                stop_found,
  output logic [NUM_BITS-1:0] rx_data,
  output logic                byte_received,
  output logic                check_ack,
  output logic                ack_sample,
  output logic                ack_done,
  output logic [3:0]          bit_count
);

  localparam logic [3:0] LAST_BIT = 4'(NUM_BITS - 1);

  logic scl_sync;
  logic sda_sync;
  logic scl_rise;
  logic scl_fall;

  rx_state_t           state_q,         state_d;
  logic                scl_prev_q,      scl_prev_d;
  logic [NUM_BITS-1:0] rx_data_q,       rx_data_d;
  logic [3:0]          bit_count_q,     bit_count_d;
  logic                ack_sample_q,    ack_sample_d;
  logic                byte_received_q, byte_received_d;
  logic                check_ack_q,     check_ack_d;
  logic                ack_done_q,      ack_done_d;

  sync_high u_sync_scl (
    .clk      (clk),
    .n_rst    (n_rst),
    .async_in (scl),
    .sync_out (scl_sync)
  );

  sync_high u_sync_sda (
    .clk      (clk),
    .n_rst    (n_rst),
    .async_in (sda_in),
    .sync_out (sda_sync)
  );

  assign scl_rise = scl_sync & ~scl_prev_q;
  assign scl_fall = ~scl_sync & scl_prev_q;

  always_comb begin
    state_d         = state_q;
    scl_prev_d      = scl_sync;
    rx_data_d       = rx_data_q;
    bit_count_d     = bit_count_q;
    ack_sample_d    = ack_sample_q;
    byte_received_d = 1'b0;
    check_ack_d     = 1'b0;
    ack_done_d      = 1'b0;

    // STOP beats START; both abandon any partial byte without a pulse.
    if (stop_found) begin
      state_d     = IDLE;
      bit_count_d = 4'd0;
    end else if (start_found) begin
      state_d     = SHIFT;
      bit_count_d = 4'd0;
    end else begin
      case (state_q)
        SHIFT: begin
          if (scl_rise) begin
            rx_data_d   = {rx_data_q[NUM_BITS-2:0], sda_sync};
            bit_count_d = bit_count_q + 4'd1;
            if (bit_count_q == LAST_BIT) begin
              byte_received_d = 1'b1;
              state_d         = ACK_WAIT;
            end
          end
        end
        ACK_WAIT: begin
          if (scl_fall) state_d = ACK_BIT;
        end
        ACK_BIT: begin
          if (scl_rise) begin
            ack_sample_d = sda_sync;
            check_ack_d  = 1'b1;
            state_d      = ACK_END;
          end
        end
        ACK_END: begin
          if (scl_fall) begin
            ack_done_d  = 1'b1;
            bit_count_d = 4'd0;
            state_d     = SHIFT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q         <= IDLE;
      scl_prev_q      <= 1'b1;
      rx_data_q       <= '0;
      bit_count_q     <= 4'd0;
      ack_sample_q    <= 1'b1;
      byte_received_q <= 1'b0;
      check_ack_q     <= 1'b0;
      ack_done_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      scl_prev_q      <= scl_prev_d;
      rx_data_q       <= rx_data_d;
      bit_count_q     <= bit_count_d;
      ack_sample_q    <= ack_sample_d;
      byte_received_q <= byte_received_d;
      check_ack_q     <= check_ack_d;
      ack_done_q      <= ack_done_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign bit_count     = bit_count_q;
  assign ack_sample    = ack_sample_q;
  assign byte_received = byte_received_q;
  assign check_ack     = check_ack_q;
  assign ack_done      = ack_done_q;

endmodule
